// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access stage with M/WB register and an arbitrated host port
module mem_wb_stage #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              NOOP_M,
  input  logic              ADDI_M,
  input  logic              MOVI_M,
  input  logic              LW_M,
  input  logic              SW_M,
  input  logic              WME_M,
  input  logic              WRE_M,
  input  logic [63:0]       ALU_result_M,
  input  logic [63:0]       rt_data_M,
  input  logic [4:0]        rt_M,
  input  logic [63:0]       Offset_M,
  output logic              NOOP_WB,
  output logic              LW_WB,
  output logic              WRE_WB,
  output logic [4:0]        rt_WB,
  output logic [63:0]       WB_data_WB,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [63:0]       host_wdata,
  output logic              host_ack,
  output logic [63:0]       host_rdata,
  output logic [CNT_W-1:0]  host_defer_cnt
);
  localparam logic [1:0] IDLE = 2'd0, ACK = 2'd1, RELEASE = 2'd2;
  logic [63:0] mem [2**ADDR_W];
  logic [1:0] state;
  logic [ADDR_W-1:0] addr, wr_addr;
  logic [63:0] wr_data;
  logic pipe_st, pipe_mem_op, host_go, mem_we;
  logic unused_addi;
  assign unused_addi = ADDI_M;
  always_comb begin
    addr = ALU_result_M[ADDR_W-1:0];
    pipe_st = SW_M & WME_M & ~NOOP_M;
    pipe_mem_op = (LW_M | (SW_M & WME_M)) & ~NOOP_M;
    host_go = (state == IDLE) & host_req & ~pipe_mem_op;
    mem_we = pipe_st | (host_go & host_we);
    wr_addr = pipe_st ? addr : host_addr;
    wr_data = pipe_st ? rt_data_M : host_wdata;
  end
  // host_go already excludes pipeline traffic, so one write port suffices
  always_ff @(posedge clk)
    if (mem_we) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      NOOP_WB <= 1'b0;
      LW_WB <= 1'b0;
      WRE_WB <= 1'b0;
      rt_WB <= '0;
      WB_data_WB <= '0;
    end else begin
      NOOP_WB <= NOOP_M;
      LW_WB <= LW_M & ~NOOP_M;
      WRE_WB <= WRE_M & ~NOOP_M;
      rt_WB <= NOOP_M ? '0 : rt_M;
      WB_data_WB <= NOOP_M ? '0 : MOVI_M ? Offset_M : LW_M ? mem[addr] : ALU_result_M;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      host_rdata <= '0;
      host_defer_cnt <= '0;
    end else begin
      state <= host_go ? ACK :
               state == ACK ? (host_req ? RELEASE : IDLE) :
               (state == RELEASE && !host_req) ? IDLE : state;
      if (host_go && !host_we) host_rdata <= mem[host_addr];
      if (state == IDLE && host_req && pipe_mem_op && !(&host_defer_cnt))
        host_defer_cnt <= host_defer_cnt + CNT_W'(1);
    end
  assign host_ack = (state == ACK);
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed scenarios plus randomized traffic against a behavioural model
module tb_mem_wb_stage;
  logic clk = 0, rst = 1;
  logic NOOP_M, ADDI_M, MOVI_M, LW_M, SW_M, WME_M, WRE_M;
  logic [63:0] ALU_result_M, rt_data_M, Offset_M;
  logic [4:0] rt_M;
  logic NOOP_WB, LW_WB, WRE_WB;
  logic [4:0] rt_WB;
  logic [63:0] WB_data_WB;
  logic host_req, host_we, host_ack;
  logic [7:0] host_addr;
  logic [63:0] host_wdata, host_rdata;
  logic [15:0] host_defer_cnt;
  int checks = 0, errors = 0;
  int exp_defer = 0;
  logic [63:0] mdl [256];

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .NOOP_M(NOOP_M), .ADDI_M(ADDI_M), .MOVI_M(MOVI_M),
    .LW_M(LW_M), .SW_M(SW_M), .WME_M(WME_M), .WRE_M(WRE_M),
    .ALU_result_M(ALU_result_M), .rt_data_M(rt_data_M), .rt_M(rt_M), .Offset_M(Offset_M),
    .NOOP_WB(NOOP_WB), .LW_WB(LW_WB), .WRE_WB(WRE_WB), .rt_WB(rt_WB), .WB_data_WB(WB_data_WB),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_defer_cnt(host_defer_cnt)
  );

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task clr_pipe;
    {NOOP_M, ADDI_M, MOVI_M, LW_M, SW_M, WME_M, WRE_M} = '0;
    ALU_result_M = '0;
    rt_data_M = '0;
    Offset_M = '0;
    rt_M = '0;
  endtask

  task host_go(input logic we, input logic [7:0] a, input logic [63:0] d);
    host_req = 1;
    host_we = we;
    host_addr = a;
    host_wdata = d;
  endtask

  task test_reset;
    clr_pipe();
    host_go(0, 0, 0);
    host_req = 0;
    rst = 1;
    tick();
    tick();
    checks++;
    if ({NOOP_WB, LW_WB, WRE_WB, rt_WB, WB_data_WB} !== 72'h0) begin
      errors++;
      $display("FAIL reset_wb got %h want 0", {NOOP_WB, LW_WB, WRE_WB, rt_WB, WB_data_WB});
    end
    checks++;
    if ({host_ack, host_rdata, host_defer_cnt} !== 81'h0) begin
      errors++;
      $display("FAIL reset_host got %h want 0", {host_ack, host_rdata, host_defer_cnt});
    end
    rst = 0;
    exp_defer = 0;
    tick();
  endtask

  task test_movi;
    MOVI_M = 1; WRE_M = 1; rt_M = 1; Offset_M = 9; ALU_result_M = 64'h77;
    tick();
    checks++;
    if ({WB_data_WB, WRE_WB, rt_WB, NOOP_WB} !== {64'd9, 1'b1, 5'd1, 1'b0}) begin
      errors++;
      $display("FAIL movi got %h/%b/%0d want 9/1/1", WB_data_WB, WRE_WB, rt_WB);
    end
    NOOP_M = 1;
    tick();
    checks++;
    if ({WB_data_WB, WRE_WB, rt_WB, LW_WB, NOOP_WB} !== {64'd0, 1'b0, 5'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL noop got %h/%b/%0d/%b/%b want 0/0/0/0/1", WB_data_WB, WRE_WB, rt_WB, LW_WB, NOOP_WB);
    end
    clr_pipe();
  endtask

  task test_store_load;
    SW_M = 1; WME_M = 1; ALU_result_M = 24; rt_data_M = 64'hDEAD;
    tick();
    clr_pipe();
    LW_M = 1; ALU_result_M = 24; rt_M = 2; WRE_M = 1;
    tick();
    checks++;
    if ({WB_data_WB, LW_WB, rt_WB} !== {64'hDEAD, 1'b1, 5'd2}) begin
      errors++;
      $display("FAIL store_load got %h/%b/%0d want dead/1/2", WB_data_WB, LW_WB, rt_WB);
    end
    ALU_result_M = 24 + 256;
    tick();
    checks++;
    if (WB_data_WB !== 64'hDEAD) begin
      errors++;
      $display("FAIL alias_load got %h want dead", WB_data_WB);
    end
    clr_pipe();
    SW_M = 1; WME_M = 1; ALU_result_M = 64'hFF00_0000_0000_0118; rt_data_M = 64'hBEEF;
    tick();
    clr_pipe();
    LW_M = 1; ALU_result_M = 24;
    tick();
    checks++;
    if (WB_data_WB !== 64'hBEEF) begin
      errors++;
      $display("FAIL alias_store got %h want beef", WB_data_WB);
    end
    clr_pipe();
  endtask

  task test_host;
    host_go(1, 5, 64'h1234);
    tick();
    checks++;
    if (host_ack !== 1'b1) begin
      errors++;
      $display("FAIL host_write_ack got %b want 1", host_ack);
    end
    host_req = 0;
    tick();
    checks++;
    if (host_ack !== 1'b0) begin
      errors++;
      $display("FAIL host_ack_pulse got %b want 0", host_ack);
    end
    host_go(0, 5, 0);
    tick();
    checks++;
    if ({host_ack, host_rdata} !== {1'b1, 64'h1234}) begin
      errors++;
      $display("FAIL host_read got %b/%h want 1/1234", host_ack, host_rdata);
    end
    host_req = 0;
    LW_M = 1; ALU_result_M = 5;
    tick();
    checks++;
    if ({host_ack, host_rdata, WB_data_WB} !== {1'b0, 64'h1234, 64'h1234}) begin
      errors++;
      $display("FAIL host_hold_pipe_load got %b/%h/%h want 0/1234/1234", host_ack, host_rdata, WB_data_WB);
    end
    clr_pipe();
    host_go(1, 6, 64'h77);
    tick();
    host_req = 0;
    LW_M = 1; ALU_result_M = 6;
    tick();
    checks++;
    if (WB_data_WB !== 64'h77) begin
      errors++;
      $display("FAIL load_after_host_write got %h want 77", WB_data_WB);
    end
    clr_pipe();
  endtask

  task test_conflict;
    host_go(0, 5, 0);
    LW_M = 1; ALU_result_M = 10;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_defer++;
      checks++;
      if ({host_ack, host_defer_cnt} !== {1'b0, 16'(exp_defer)}) begin
        errors++;
        $display("FAIL conflict_c%0d got ack %b cnt %0d want 0 %0d", i, host_ack, host_defer_cnt, exp_defer);
      end
    end
    clr_pipe();
    ADDI_M = 1; WRE_M = 1; ALU_result_M = 1;
    tick();
    checks++;
    if ({host_ack, host_defer_cnt, host_rdata, WB_data_WB} !== {1'b1, 16'(exp_defer), 64'h1234, 64'd1}) begin
      errors++;
      $display("FAIL conflict_ack got %b/%0d/%h/%h want 1/%0d/1234/1", host_ack, host_defer_cnt, host_rdata, WB_data_WB, exp_defer);
    end
    host_req = 0;
    clr_pipe();
    tick();
  endtask

  task test_back_to_back;
    host_go(1, 9, 64'h55);
    tick();
    checks++;
    if (host_ack !== 1'b1) begin
      errors++;
      $display("FAIL held_first_ack got %b want 1", host_ack);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (host_ack !== 1'b0) begin
        errors++;
        $display("FAIL held_no_reack%0d got %b want 0", i, host_ack);
      end
    end
    host_req = 0;
    tick();
    host_go(0, 9, 0);
    tick();
    checks++;
    if ({host_ack, host_rdata} !== {1'b1, 64'h55}) begin
      errors++;
      $display("FAIL second_ack got %b/%h want 1/55", host_ack, host_rdata);
    end
    host_req = 0;
    tick();
  endtask

  task test_reset_mid;
    host_go(1, 3, 64'hCAFE);
    tick();
    host_req = 0;
    tick();
    host_go(1, 12, 64'h1111);
    MOVI_M = 1; WRE_M = 1; Offset_M = 5; rt_M = 4;
    tick();
    checks++;
    if ({host_ack, WB_data_WB} !== {1'b1, 64'd5}) begin
      errors++;
      $display("FAIL pre_reset got %b/%h want 1/5", host_ack, WB_data_WB);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({NOOP_WB, LW_WB, WRE_WB, rt_WB, WB_data_WB, host_ack, host_rdata, host_defer_cnt} !== 153'h0) begin
      errors++;
      $display("FAIL async_reset ack %b wb %h cnt %0d want all 0", host_ack, WB_data_WB, host_defer_cnt);
    end
    exp_defer = 0;
    host_req = 0;
    clr_pipe();
    #2 rst = 0;
    tick();
    host_go(0, 3, 0);
    tick();
    checks++;
    if ({host_ack, host_rdata} !== {1'b1, 64'hCAFE}) begin
      errors++;
      $display("FAIL mem_survives_reset got %b/%h want 1/cafe", host_ack, host_rdata);
    end
    host_req = 0;
    tick();
  endtask

  task test_random;
    bit can_serve, serve, acked, pipe_op;
    logic [71:0] e_wb;
    logic [63:0] e_rd;
    int a;
    for (int i = 0; i < 256; i++) begin
      clr_pipe();
      SW_M = 1; WME_M = 1; ALU_result_M = 64'(i); rt_data_M = {$urandom, $urandom};
      mdl[i] = rt_data_M;
      tick();
    end
    can_serve = 1;
    acked = 0;
    e_rd = '0;
    for (int c = 0; c < 600; c++) begin
      NOOP_M = ($urandom_range(0, 7) == 0);
      LW_M = ($urandom_range(0, 2) == 0);
      SW_M = ($urandom_range(0, 2) == 0);
      WME_M = $urandom_range(0, 1);
      MOVI_M = ($urandom_range(0, 3) == 0);
      ADDI_M = $urandom_range(0, 1);
      WRE_M = $urandom_range(0, 1);
      rt_M = 5'($urandom);
      ALU_result_M = {$urandom, $urandom};
      rt_data_M = {$urandom, $urandom};
      Offset_M = {$urandom, $urandom};
      a = int'(ALU_result_M % 256);
      pipe_op = (LW_M || (SW_M && WME_M)) && !NOOP_M;
      if (NOOP_M) e_wb = {1'b1, 1'b0, 1'b0, 5'd0, 64'd0};
      else e_wb = {1'b0, LW_M, WRE_M, rt_M, MOVI_M ? Offset_M : LW_M ? mdl[a] : ALU_result_M};
      serve = can_serve && host_req && !pipe_op;
      if (serve && !host_we) e_rd = mdl[host_addr];
      if (can_serve && host_req && pipe_op && exp_defer < 65535) exp_defer++;
      if (!can_serve && !host_req) can_serve = 1;
      if (serve) can_serve = 0;
      if (SW_M && WME_M && !NOOP_M) mdl[a] = rt_data_M;
      if (serve && host_we) mdl[host_addr] = host_wdata;
      tick();
      checks++;
      if ({NOOP_WB, LW_WB, WRE_WB, rt_WB, WB_data_WB} !== e_wb) begin
        errors++;
        $display("FAIL rand_wb c%0d got %h want %h", c, {NOOP_WB, LW_WB, WRE_WB, rt_WB, WB_data_WB}, e_wb);
      end
      checks++;
      if ({host_ack, host_defer_cnt} !== {serve, 16'(exp_defer)}) begin
        errors++;
        $display("FAIL rand_host c%0d got ack %b cnt %0d want %b %0d", c, host_ack, host_defer_cnt, serve, exp_defer);
      end
      if (serve && !host_we) begin
        checks++;
        if (host_rdata !== e_rd) begin
          errors++;
          $display("FAIL rand_rdata c%0d got %h want %h", c, host_rdata, e_rd);
        end
      end
      if (host_req) begin
        if (serve) acked = 1;
        if (acked && $urandom_range(0, 2) != 0) begin
          host_req = 0;
          acked = 0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        host_go($urandom_range(0, 1), 8'($urandom), {$urandom, $urandom});
      end
    end
    host_req = 0;
    clr_pipe();
    tick();
  endtask

  initial begin
    test_reset();
    test_movi();
    test_store_load();
    test_host();
    test_conflict();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
